// File: rtl/crank_cam_gen_if.sv
// Control and observation bundle for crank_cam_gen.
// load is a one-cycle strobe with no ready: a value held on period_in while load=1 is always taken on that clk edge.
interface crank_cam_gen_if #(
    parameter int TEETH = 60,
    parameter int DIV_W = 16
);
    localparam int TW = $clog2(TEETH);

    logic                    en;
    logic                    load;
    logic        [DIV_W-1:0] period_in;
    logic signed [DIV_W-1:0] accel;
    logic                    vr_out;
    logic                    cam_out;
    logic        [TW-1:0]    tooth_cnt;
    logic                    rev_tick;
    logic        [DIV_W-1:0] period;

    modport master (
        output en, load, period_in, accel,
        input  vr_out, cam_out, tooth_cnt, rev_tick, period
    );

    modport slave (
        input  en, load, period_in, accel,
        output vr_out, cam_out, tooth_cnt, rev_tick, period
    );
endinterface

// File: rtl/crank_cam_gen.sv
// Crank (missing-tooth) and cam signal generator with programmable, accelerating period.
// Macro CRANK_CAM_GEN_CAM_EN enables the 720-degree cam phase and cam_out window.
module crank_cam_gen #(
    parameter int TEETH      = 60,
    parameter int MISSING    = 2,
    parameter int SUB        = 64,
    parameter int DIV_W      = 16,
    parameter int PERIOD_MIN = 1,
    parameter int PERIOD_RST = 128,
    parameter int CAM_ON     = 4,
    parameter int CAM_OFF    = 54
) (
    input  logic           clk,
    input  logic           rst_n,
    crank_cam_gen_if.slave bus
);
    localparam int TW = $clog2(TEETH);
    localparam int SW = $clog2(SUB);
    localparam logic [DIV_W-1:0] P_MIN  = DIV_W'(PERIOD_MIN);
    localparam logic [DIV_W-1:0] P_RST  = DIV_W'(PERIOD_RST);
    localparam logic [DIV_W-1:0] P_MAX  = {DIV_W{1'b1}};
    localparam logic [SW-1:0]    SUB_LAST = SW'(SUB - 1);
    localparam logic [SW-1:0]    SUB_HALF = SW'(SUB / 2);
    localparam logic [TW-1:0]    TOOTH_LAST = TW'(TEETH - 1);
    localparam logic [TW:0]      VR_LIMIT = (TW+1)'(TEETH - MISSING);

    if (SUB < 2 || (SUB % 2) != 0) begin : g_bad_sub
        $error("crank_cam_gen: SUB must be even and at least 2");
    end
    if (CAM_ON > CAM_OFF || CAM_OFF > TEETH || MISSING >= TEETH) begin : g_bad_window
        $error("crank_cam_gen: cam window or missing-tooth count out of range");
    end

    logic [DIV_W-1:0] div_cnt;
    logic [SW-1:0]    sub_cnt;
    logic [TW-1:0]    tooth_q;
    logic [DIV_W-1:0] period_q;
    logic [DIV_W-1:0] period_nxt;
    logic [DIV_W-1:0] pend_q;
    logic             pend_vld;
    logic             rev_q;

    logic             sub_wrap;
    logic             tooth_wrap;
    logic             rev_wrap;
    logic [DIV_W-1:0] load_val;
    logic signed [DIV_W+1:0] accel_sum;
    logic [DIV_W-1:0] accel_sat;

    assign sub_wrap   = bus.en && (div_cnt == period_q);
    assign tooth_wrap = sub_wrap && (sub_cnt == SUB_LAST);
    assign rev_wrap   = tooth_wrap && (tooth_q == TOOTH_LAST);
    assign load_val   = (bus.period_in < P_MIN) ? P_MIN : bus.period_in;

    // Two guard bits keep both underflow below zero and overflow past P_MAX visible.
    assign accel_sum = $signed({2'b00, period_q}) + $signed({{2{bus.accel[DIV_W-1]}}, bus.accel});

    always_comb begin
        accel_sat = accel_sum[DIV_W-1:0];
        if (accel_sum < $signed({2'b00, P_MIN})) begin
            accel_sat = P_MIN;
        end else if (accel_sum > $signed({2'b00, P_MAX})) begin
            accel_sat = P_MAX;
        end
    end

    // A load on the boundary cycle wins over an older pending value and over accel.
    always_comb begin
        period_nxt = period_q;
        if (tooth_wrap) begin
            if (bus.load) begin
                period_nxt = load_val;
            end else if (pend_vld) begin
                period_nxt = pend_q;
            end else begin
                period_nxt = accel_sat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            sub_cnt  <= '0;
            tooth_q  <= '0;
            period_q <= P_RST;
            rev_q    <= 1'b0;
        end else if (bus.en) begin
            div_cnt  <= sub_wrap ? '0 : div_cnt + 1'b1;
            period_q <= period_nxt;
            rev_q    <= rev_wrap;
            if (sub_wrap) begin
                sub_cnt <= (sub_cnt == SUB_LAST) ? '0 : sub_cnt + 1'b1;
            end
            if (tooth_wrap) begin
                tooth_q <= (tooth_q == TOOTH_LAST) ? '0 : tooth_q + 1'b1;
            end
        end
    end

    // Pending capture runs even while en=0 so a period can be staged before starting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q   <= '0;
            pend_vld <= 1'b0;
        end else begin
            if (bus.load) begin
                pend_q <= load_val;
            end
            if (tooth_wrap) begin
                pend_vld <= 1'b0;
            end else if (bus.load) begin
                pend_vld <= 1'b1;
            end
        end
    end

    assign bus.vr_out    = (sub_cnt >= SUB_HALF) && ({1'b0, tooth_q} < VR_LIMIT);
    assign bus.tooth_cnt = tooth_q;
    assign bus.rev_tick  = rev_q;
    assign bus.period    = period_q;

`ifdef CRANK_CAM_GEN_CAM_EN
    localparam logic [TW:0] CAM_ON_W  = (TW+1)'(CAM_ON);
    localparam logic [TW:0] CAM_OFF_W = (TW+1)'(CAM_OFF);

    logic cam_phase;

    // The cam turns once per two crank revolutions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cam_phase <= 1'b0;
        end else if (rev_wrap) begin
            cam_phase <= ~cam_phase;
        end
    end

    assign bus.cam_out = cam_phase && ({1'b0, tooth_q} >= CAM_ON_W) && ({1'b0, tooth_q} < CAM_OFF_W);
`else
    assign bus.cam_out = 1'b0;
`endif
endmodule

// File: doc/crank_cam_gen.md
CRANK_CAM_GEN -- requirements
Module: crank_cam_gen

Interface
REQ-001 SHALL have parameter TEETH, default 60: tooth slots per crank revolution, including missing slots.
REQ-002 SHALL have parameter MISSING, default 2: missing-tooth slots at the end of the revolution.
REQ-003 SHALL have parameter SUB, default 64 (even, >=2): sub-ticks per tooth slot.
REQ-004 SHALL have parameter DIV_W, default 16: width of the period and divider counters.
REQ-005 SHALL have parameter PERIOD_MIN, default 1, and PERIOD_RST, default 128: period saturation floor and reset value.
REQ-006 SHALL have parameters CAM_ON, default 4, and CAM_OFF, default 54: tooth indices bounding the cam window.
REQ-007 clk  in  1  single clock; all state changes on its rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 en  in  1  run enable; when low, all state holds.
REQ-010 load  in  1  one-cycle strobe that captures period_in.
REQ-011 period_in  in  DIV_W  new sub-tick period (clk cycles minus one).
REQ-012 accel  in  DIV_W signed  period delta applied at each tooth boundary.
REQ-013 vr_out  out  1  crank tooth signal.
REQ-014 cam_out  out  1  cam window signal.
REQ-015 tooth_cnt  out  $clog2(TEETH)  current tooth slot index.
REQ-016 rev_tick  out  1  one-cycle pulse at the start of each revolution.
REQ-017 period  out  DIV_W  currently active period.

Function
REQ-018 div_cnt SHALL count clk cycles while en=1, wrapping to 0 when it equals period; one sub-tick therefore lasts period+1 cycles.
REQ-019 sub_cnt SHALL advance on each div_cnt wrap and wrap from SUB-1 to 0; this wrap is the tooth boundary.
REQ-020 tooth_cnt SHALL advance at each tooth boundary and wrap from TEETH-1 to 0.
REQ-021 rev_tick SHALL be high for exactly the first cycle in which tooth_cnt=0 after a wrap, and SHALL NOT pulse after reset.
REQ-022 vr_out SHALL be a decode of the registered counters: 1 iff sub_cnt >= SUB/2 and tooth_cnt < TEETH-MISSING.
REQ-023 At each tooth boundary without load, period SHALL become period+accel, saturated to [PERIOD_MIN, 2^DIV_W-1].
REQ-024 load SHALL capture period_in into a pending register; the pending value SHALL become period at the next tooth boundary, taking the place of the accel update there.
REQ-025 A period_in value below PERIOD_MIN SHALL be clamped to PERIOD_MIN.
REQ-026 If load coincides with a tooth boundary, the newly loaded value SHALL be applied at that boundary.
REQ-027 If load repeats before a boundary, the last value SHALL win.
REQ-028 The cam_phase register SHALL toggle on every revolution wrap, so that the cam covers 720 degrees.
REQ-029 cam_out SHALL be 1 iff cam_phase=1 and CAM_ON <= tooth_cnt < CAM_OFF.
REQ-030 With en=0, the counters, period and outputs SHALL hold; load SHALL still be captured.

Reset
REQ-031 On rst_n=0, regardless of clk, the following SHALL clear to 0 and stay there while rst_n=0: div_cnt, sub_cnt, tooth_cnt, cam_phase, rev_tick, vr_out, cam_out and the pending-load flag.
REQ-032 On rst_n=0, period SHALL be set to PERIOD_RST and stay there while rst_n=0.
REQ-033 Reset asserted mid-revolution SHALL abandon the revolution; counting SHALL restart from tooth 0, sub-tick 0, on the first enabled cycle after release.

Configuration
REQ-034 Macro CRANK_CAM_GEN_CAM_EN SHALL control the cam logic.
REQ-035 With CRANK_CAM_GEN_CAM_EN defined, cam_phase and the cam_out logic per REQ-028/029 SHALL be present.
REQ-036 With CRANK_CAM_GEN_CAM_EN undefined, the cam_out port SHALL remain and be tied to 0, and no cam_phase register SHALL exist.

Verification
REQ-037 TEETH=60, MISSING=2, SUB=4, period_in=1 loaded, accel=0 -> tooth slot 8 cycles; revolution 480 cycles; vr_out high 4 cycles per tooth; gap low run 20 cycles; rev_tick period 480.
REQ-038 period=10, accel=-1, PERIOD_MIN=4 -> period 9,8,7,6,5,4 at successive boundaries, then stays 4.
REQ-039 period=65534, accel=+5 -> period saturates at 65535.
REQ-040 load period_in=3 in the same cycle as a tooth boundary -> next slot uses period 3 and accel is ignored at that boundary; a load mid-slot is applied at the next boundary.
REQ-041 Cam build, defaults -> cam_out high for teeth 4..53 on alternate revolutions only; non-cam build -> cam_out constant 0.
REQ-042 rst_n pulled low at tooth 30 sub 2, then en held low for 5 cycles after release -> all outputs 0, period=PERIOD_RST, and counting starts at tooth 0 when en rises.
